// File: rtl/syn_fft_pkg.sv
// rtl/syn_fft_pkg.sv - shared types and constants for the FFT sample cache
package syn_fft_pkg;

   // Cycles from a read strobe to the cycle its data is presented
   localparam int FFT_CACHE_RD_LAT = 2;

   // RUN: normal operation; DRAIN: swap requested, waiting for host reads to leave the RAM stage
   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } cache_state_e;

   // Host address LSB selects the component of a sample
   localparam logic PART_RE = 1'b0;
   localparam logic PART_IM = 1'b1;

endpackage

// File: rtl/syn_fft_cache_bank.sv
// rtl/syn_fft_cache_bank.sv - one re/im sample bank, one write port, two-stage registered read port
module syn_fft_cache_bank #(
   parameter int ADDR_W   = 8,
   parameter int SAMPLE_W = 16,
   parameter int ENTRIES  = 256
) (
   input  logic                clk,
   input  logic                we_re,
   input  logic                we_im,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [SAMPLE_W-1:0] wdata_re,
   input  logic [SAMPLE_W-1:0] wdata_im,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [SAMPLE_W-1:0] rd_re,
   output logic [SAMPLE_W-1:0] rd_im
);

   logic [SAMPLE_W-1:0] mem_re [ENTRIES];
   logic [SAMPLE_W-1:0] mem_im [ENTRIES];
   logic [SAMPLE_W-1:0] s1_re;
   logic [SAMPLE_W-1:0] s1_im;

   // Component-wise writes; the read captures pre-write contents on a same-edge collision
   always_ff @(posedge clk) begin
      if (we_re) mem_re[waddr] <= wdata_re;
      if (we_im) mem_im[waddr] <= wdata_im;
      if (rd_en) begin
         s1_re <= mem_re[raddr];
         s1_im <= mem_im[raddr];
      end
   end

   // Output stage; free-running because the owner of each slot is tracked by the top level
   always_ff @(posedge clk) begin
      rd_re <= s1_re;
      rd_im <= s1_im;
   end

endmodule

// File: rtl/syn_fft_cache_pp.sv
// rtl/syn_fft_cache_pp.sv - ping-pong multi-channel FFT sample cache, FFT engine and host on opposite banks
module syn_fft_cache_pp
   import syn_fft_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DEPTH_W  = 7,
   parameter int SAMPLE_W = 16,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = $clog2(NUM_CH) + DEPTH_W
) (
   input  logic                clk_ir,
   input  logic                rst_il,
   input  logic                fft_wr_en,
   input  logic [ADDR_W-1:0]   fft_waddr,
   input  logic [SAMPLE_W-1:0] fft_wr_re,
   input  logic [SAMPLE_W-1:0] fft_wr_im,
   input  logic                fft_rd_en,
   input  logic [ADDR_W-1:0]   fft_raddr,
   output logic [SAMPLE_W-1:0] fft_rd_re,
   output logic [SAMPLE_W-1:0] fft_rd_im,
   output logic                fft_rd_valid,
   input  logic                fft_done,
   input  logic                hst_wr_en,
   input  logic                hst_rd_en,
   input  logic [ADDR_W:0]     hst_addr,
   input  logic [DATA_W-1:0]   hst_wr_data,
   output logic [DATA_W-1:0]   hst_rd_data,
   output logic                hst_rd_valid,
   output logic                bank_sel,
   output logic                swap_busy,
   output logic [7:0]          frame_cnt,
   output logic                acc_err
);

   localparam int CH_W    = $clog2(NUM_CH);
   localparam int ENTRIES = NUM_CH << DEPTH_W;

   // Channel field beyond the populated channels (only possible for non-power-of-2 NUM_CH)
   function automatic logic ch_oob(input logic [ADDR_W-1:0] a);
      return 32'(a[ADDR_W-1 -: CH_W]) >= NUM_CH;
   endfunction

   cache_state_e state, state_nxt;
   logic         drain, swap, err_nxt;

   logic [ADDR_W-1:0]   hst_word;
   logic                hst_part;
   logic [SAMPLE_W-1:0] hst_wr_sample;
   logic fft_w_oob, fft_r_oob, hst_oob;
   logic fft_wr_ok, fft_rd_go, fft_rd_mem;
   logic hst_wr_ok, hst_rd_go, hst_rd_mem;

   // Read-return tracking: valid, source bank, out-of-range, and (host) component
   logic fft_v1, fft_v2, fft_b1, fft_b2, fft_z1, fft_z2;
   logic hst_v1, hst_v2, hst_b1, hst_b2, hst_z1, hst_z2, hst_p1, hst_p2;

   logic                b_we_re [2];
   logic                b_we_im [2];
   logic [ADDR_W-1:0]   b_waddr [2];
   logic [SAMPLE_W-1:0] b_wre   [2];
   logic [SAMPLE_W-1:0] b_wim   [2];
   logic                b_rd_en [2];
   logic [ADDR_W-1:0]   b_raddr [2];
   logic [SAMPLE_W-1:0] b_rd_re [2];
   logic [SAMPLE_W-1:0] b_rd_im [2];

   logic [SAMPLE_W-1:0] fft_sel_re, fft_sel_im, hst_sel;

   assign drain         = (state == DRAIN);
   assign swap_busy     = drain;
   assign hst_word      = hst_addr[ADDR_W:1];
   assign hst_part      = hst_addr[0];
   assign hst_wr_sample = hst_wr_data[SAMPLE_W-1:0];

   assign fft_w_oob  = ch_oob(fft_waddr);
   assign fft_r_oob  = ch_oob(fft_raddr);
   assign hst_oob    = ch_oob(hst_word);

   // Everything new is refused while draining; out-of-range writes never reach a bank
   assign fft_wr_ok  = fft_wr_en & ~drain & ~fft_w_oob;
   assign fft_rd_go  = fft_rd_en & ~drain;
   assign fft_rd_mem = fft_rd_go & ~fft_r_oob;
   assign hst_wr_ok  = hst_wr_en & ~drain & ~hst_oob;
   assign hst_rd_go  = hst_rd_en & ~drain;
   assign hst_rd_mem = hst_rd_go & ~hst_oob;

   generate
      if (DATA_W > SAMPLE_W) begin : g_hi_unused
         logic unused_hst_hi;
         assign unused_hst_hi = ^hst_wr_data[DATA_W-1:SAMPLE_W];
      end
   endgenerate

   // Route each bank's ports to the FFT side when it owns the bank, otherwise to the host
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         b_we_re[b] = 1'b0;
         b_we_im[b] = 1'b0;
         b_waddr[b] = '0;
         b_wre[b]   = '0;
         b_wim[b]   = '0;
         b_rd_en[b] = 1'b0;
         b_raddr[b] = '0;
         if (bank_sel == 1'(b)) begin
            b_we_re[b] = fft_wr_ok;
            b_we_im[b] = fft_wr_ok;
            b_waddr[b] = fft_waddr;
            b_wre[b]   = fft_wr_re;
            b_wim[b]   = fft_wr_im;
            b_rd_en[b] = fft_rd_mem;
            b_raddr[b] = fft_raddr;
         end else begin
            b_we_re[b] = hst_wr_ok & (hst_part == PART_RE);
            b_we_im[b] = hst_wr_ok & (hst_part == PART_IM);
            b_waddr[b] = hst_word;
            b_wre[b]   = hst_wr_sample;
            b_wim[b]   = hst_wr_sample;
            b_rd_en[b] = hst_rd_mem;
            b_raddr[b] = hst_word;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      syn_fft_cache_bank #(
         .ADDR_W   (ADDR_W),
         .SAMPLE_W (SAMPLE_W),
         .ENTRIES  (ENTRIES)
      ) u_bank (
         .clk      (clk_ir),
         .we_re    (b_we_re[g]),
         .we_im    (b_we_im[g]),
         .waddr    (b_waddr[g]),
         .wdata_re (b_wre[g]),
         .wdata_im (b_wim[g]),
         .rd_en    (b_rd_en[g]),
         .raddr    (b_raddr[g]),
         .rd_re    (b_rd_re[g]),
         .rd_im    (b_rd_im[g])
      );
   end

   // Swap control: swap at once when no host read is in the RAM stage, otherwise drain first
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         RUN: begin
            if (fft_done) begin
               if (!hst_v1 && !hst_rd_en) swap = 1'b1;
               else                       state_nxt = DRAIN;
            end
            err_nxt = (fft_wr_en & fft_w_oob) | (fft_rd_en & fft_r_oob) |
                      ((hst_wr_en | hst_rd_en) & hst_oob);
         end
         DRAIN: begin
            if (!hst_v1) begin
               swap      = 1'b1;
               state_nxt = RUN;
            end
            err_nxt = fft_wr_en | fft_rd_en | hst_wr_en | hst_rd_en | fft_done;
         end
         default: state_nxt = RUN;
      endcase
   end

   // State, bank ownership, frame counter and error pulse
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         state     <= RUN;
         bank_sel  <= 1'b0;
         frame_cnt <= 8'd0;
         acc_err   <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc_err <= err_nxt;
         if (swap) begin
            bank_sel  <= ~bank_sel;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Tag pipelines remember the issuing bank so in-flight reads survive a swap
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         fft_v1 <= 1'b0; fft_v2 <= 1'b0;
         fft_b1 <= 1'b0; fft_b2 <= 1'b0;
         fft_z1 <= 1'b0; fft_z2 <= 1'b0;
         hst_v1 <= 1'b0; hst_v2 <= 1'b0;
         hst_b1 <= 1'b0; hst_b2 <= 1'b0;
         hst_z1 <= 1'b0; hst_z2 <= 1'b0;
         hst_p1 <= 1'b0; hst_p2 <= 1'b0;
      end else begin
         fft_v1 <= fft_rd_go;  fft_v2 <= fft_v1;
         fft_b1 <= bank_sel;   fft_b2 <= fft_b1;
         fft_z1 <= fft_r_oob;  fft_z2 <= fft_z1;
         hst_v1 <= hst_rd_go;  hst_v2 <= hst_v1;
         hst_b1 <= ~bank_sel;  hst_b2 <= hst_b1;
         hst_z1 <= hst_oob;    hst_z2 <= hst_z1;
         hst_p1 <= hst_part;   hst_p2 <= hst_p1;
      end
   end

   assign fft_sel_re = fft_b2 ? b_rd_re[1] : b_rd_re[0];
   assign fft_sel_im = fft_b2 ? b_rd_im[1] : b_rd_im[0];
   assign hst_sel    = (hst_p2 == PART_IM) ? (hst_b2 ? b_rd_im[1] : b_rd_im[0])
                                           : (hst_b2 ? b_rd_re[1] : b_rd_re[0]);

   assign fft_rd_valid = fft_v2;
   assign fft_rd_re    = (fft_v2 && !fft_z2) ? fft_sel_re : '0;
   assign fft_rd_im    = (fft_v2 && !fft_z2) ? fft_sel_im : '0;
   assign hst_rd_valid = hst_v2;
   assign hst_rd_data  = (hst_v2 && !hst_z2) ? DATA_W'($signed(hst_sel)) : '0;

endmodule

// File: tb/tb_syn_fft_cache_pp.sv
// tb/tb_syn_fft_cache_pp.sv - directed self-checking bench for syn_fft_cache_pp
module tb_syn_fft_cache_pp;

   logic        clk_ir = 1'b0;
   logic        rst_il;
   logic        fft_wr_en;
   logic [7:0]  fft_waddr;
   logic [15:0] fft_wr_re, fft_wr_im;
   logic        fft_rd_en;
   logic [7:0]  fft_raddr;
   logic [15:0] fft_rd_re, fft_rd_im;
   logic        fft_rd_valid;
   logic        fft_done;
   logic        hst_wr_en, hst_rd_en;
   logic [8:0]  hst_addr;
   logic [31:0] hst_wr_data, hst_rd_data;
   logic        hst_rd_valid;
   logic        bank_sel, swap_busy, acc_err;
   logic [7:0]  frame_cnt;

   int total = 0;
   int bad   = 0;

   syn_fft_cache_pp dut (
      .clk_ir(clk_ir), .rst_il(rst_il),
      .fft_wr_en(fft_wr_en), .fft_waddr(fft_waddr), .fft_wr_re(fft_wr_re), .fft_wr_im(fft_wr_im),
      .fft_rd_en(fft_rd_en), .fft_raddr(fft_raddr), .fft_rd_re(fft_rd_re), .fft_rd_im(fft_rd_im),
      .fft_rd_valid(fft_rd_valid), .fft_done(fft_done),
      .hst_wr_en(hst_wr_en), .hst_rd_en(hst_rd_en), .hst_addr(hst_addr),
      .hst_wr_data(hst_wr_data), .hst_rd_data(hst_rd_data), .hst_rd_valid(hst_rd_valid),
      .bank_sel(bank_sel), .swap_busy(swap_busy), .frame_cnt(frame_cnt), .acc_err(acc_err)
   );

   always #5 clk_ir = ~clk_ir;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_ir);
      #1;
   endtask

   task automatic fft_write(input logic [7:0] a, input logic [15:0] re, input logic [15:0] im);
      fft_wr_en = 1'b1; fft_waddr = a; fft_wr_re = re; fft_wr_im = im;
      cyc();
      fft_wr_en = 1'b0;
   endtask

   task automatic fft_read(input logic [7:0] a, input logic [15:0] re, input logic [15:0] im,
                           input string tag);
      fft_rd_en = 1'b1; fft_raddr = a;
      cyc();
      fft_rd_en = 1'b0;
      chk({tag, "_early"}, 32'(fft_rd_valid), 32'd0);
      cyc();
      chk({tag, "_valid"}, 32'(fft_rd_valid), 32'd1);
      chk({tag, "_re"}, 32'(fft_rd_re), 32'(re));
      chk({tag, "_im"}, 32'(fft_rd_im), 32'(im));
   endtask

   task automatic hst_read(input logic [8:0] a, input logic [31:0] exp, input string tag);
      hst_rd_en = 1'b1; hst_addr = a;
      cyc();
      hst_rd_en = 1'b0;
      chk({tag, "_early"}, 32'(hst_rd_valid), 32'd0);
      cyc();
      chk({tag, "_valid"}, 32'(hst_rd_valid), 32'd1);
      chk({tag, "_data"}, hst_rd_data, exp);
   endtask

   task automatic hst_write(input logic [8:0] a, input logic [31:0] d);
      hst_wr_en = 1'b1; hst_addr = a; hst_wr_data = d;
      cyc();
      hst_wr_en = 1'b0;
   endtask

   task automatic pulse_done();
      fft_done = 1'b1;
      cyc();
      fft_done = 1'b0;
   endtask

   initial begin
      rst_il = 1'b0;
      fft_wr_en = 1'b0; fft_waddr = '0; fft_wr_re = '0; fft_wr_im = '0;
      fft_rd_en = 1'b0; fft_raddr = '0; fft_done = 1'b0;
      hst_wr_en = 1'b0; hst_rd_en = 1'b0; hst_addr = '0; hst_wr_data = '0;

      // Reset values
      cyc(); cyc();
      chk("rst_bank_sel", 32'(bank_sel), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_swap_busy", 32'(swap_busy), 32'd0);
      chk("rst_fft_valid", 32'(fft_rd_valid), 32'd0);
      chk("rst_hst_valid", 32'(hst_rd_valid), 32'd0);
      chk("rst_acc_err", 32'(acc_err), 32'd0);
      chk("rst_hst_data", hst_rd_data, 32'd0);
      rst_il = 1'b1;
      cyc();

      // FFT writes {ch1, idx5} into bank 0, swap, host reads it back from bank 0
      fft_write(8'h85, 16'h1234, 16'hFEDC);
      pulse_done();
      chk("swap1_bank_sel", 32'(bank_sel), 32'd1);
      chk("swap1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("swap1_busy", 32'(swap_busy), 32'd0);
      hst_read(9'h10A, 32'h0000_1234, "h_re");
      hst_read(9'h10B, 32'hFFFF_FEDC, "h_im");

      // Fill bank 1 addresses 0..7, then stream reads back to back
      for (int i = 0; i < 8; i++) fft_write(8'(i), 16'h0100 + 16'(i), 16'hF000 + 16'(i));
      for (int c = 0; c < 10; c++) begin
         fft_rd_en = (c < 8); fft_raddr = 8'(c);
         cyc();
         if (c >= 1 && c <= 8) begin
            chk($sformatf("burst_valid_%0d", c), 32'(fft_rd_valid), 32'd1);
            chk($sformatf("burst_re_%0d", c), 32'(fft_rd_re), 32'h0100 + 32'(c - 1));
            chk($sformatf("burst_im_%0d", c), 32'(fft_rd_im), 32'hF000 + 32'(c - 1));
         end else begin
            chk($sformatf("burst_idle_%0d", c), 32'(fft_rd_valid), 32'd0);
         end
      end
      fft_rd_en = 1'b0;

      // Same-edge write and read at address 3: read sees the old value
      fft_write(8'd3, 16'd7, 16'd7);
      fft_wr_en = 1'b1; fft_waddr = 8'd3; fft_wr_re = 16'd9; fft_wr_im = 16'd9;
      fft_rd_en = 1'b1; fft_raddr = 8'd3;
      cyc();
      fft_wr_en = 1'b0; fft_rd_en = 1'b0;
      cyc();
      chk("rw_old_valid", 32'(fft_rd_valid), 32'd1);
      chk("rw_old_re", 32'(fft_rd_re), 32'd7);
      fft_read(8'd3, 16'd9, 16'd9, "rw_new");

      // Host read together with fft_done forces a two-cycle drain
      hst_rd_en = 1'b1; hst_addr = 9'h10A; fft_done = 1'b1;
      cyc();
      hst_rd_en = 1'b0; fft_done = 1'b0;
      chk("drain0_busy", 32'(swap_busy), 32'd1);
      chk("drain0_bank", 32'(bank_sel), 32'd1);
      chk("drain0_err", 32'(acc_err), 32'd0);
      fft_wr_en = 1'b1; fft_waddr = 8'd3; fft_wr_re = 16'hDEAD; fft_wr_im = 16'hDEAD;
      fft_done = 1'b1;
      cyc();
      fft_wr_en = 1'b0; fft_done = 1'b0;
      chk("drain1_busy", 32'(swap_busy), 32'd1);
      chk("drain1_err", 32'(acc_err), 32'd1);
      chk("drain1_hvalid", 32'(hst_rd_valid), 32'd1);
      chk("drain1_hdata", hst_rd_data, 32'h0000_1234);
      chk("drain1_cnt", 32'(frame_cnt), 32'd1);
      cyc();
      chk("drain2_busy", 32'(swap_busy), 32'd0);
      chk("drain2_bank", 32'(bank_sel), 32'd0);
      chk("drain2_cnt", 32'(frame_cnt), 32'd2);
      chk("drain2_err", 32'(acc_err), 32'd0);
      hst_read(9'h006, 32'h0000_0009, "drop_re");
      hst_read(9'h007, 32'h0000_0009, "drop_im");

      // Host writes only the imaginary half of bank 1 address 3
      hst_write(9'h007, 32'h1234_ABCD);
      hst_read(9'h007, 32'hFFFF_ABCD, "hw_im");
      hst_read(9'h006, 32'h0000_0009, "hw_re");

      // 256 swaps from reset wrap the counter and return to bank 0
      rst_il = 1'b0;
      cyc();
      rst_il = 1'b1;
      fft_done = 1'b1;
      repeat (255) @(posedge clk_ir);
      #1;
      chk("wrap255_cnt", 32'(frame_cnt), 32'd255);
      chk("wrap255_bank", 32'(bank_sel), 32'd1);
      cyc();
      fft_done = 1'b0;
      chk("wrap256_cnt", 32'(frame_cnt), 32'd0);
      chk("wrap256_bank", 32'(bank_sel), 32'd0);

      // Reset while reads are in flight
      pulse_done();
      fft_rd_en = 1'b1; fft_raddr = 8'd3;
      hst_rd_en = 1'b1; hst_addr = 9'h10A;
      cyc();
      fft_rd_en = 1'b0; hst_rd_en = 1'b0;
      cyc();
      chk("mid_fft_valid", 32'(fft_rd_valid), 32'd1);
      chk("mid_fft_re", 32'(fft_rd_re), 32'd9);
      chk("mid_fft_im", 32'(fft_rd_im), 32'hABCD);
      chk("mid_hst_valid", 32'(hst_rd_valid), 32'd1);
      chk("mid_hst_data", hst_rd_data, 32'h0000_1234);
      chk("mid_bank", 32'(bank_sel), 32'd1);
      #2;
      rst_il = 1'b0;
      #1;
      chk("arst_fft_valid", 32'(fft_rd_valid), 32'd0);
      chk("arst_hst_valid", 32'(hst_rd_valid), 32'd0);
      chk("arst_bank", 32'(bank_sel), 32'd0);
      chk("arst_cnt", 32'(frame_cnt), 32'd0);
      cyc();
      rst_il = 1'b1;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
